// File: rtl/regfile_pkg.sv
// Shared types, default parameters and helpers for the multiport register file.
package regfile_pkg;

  // Bulk-clear engine state
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Default geometry, matching the original fixed 16x16 two-read file
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

  // LSB position of lane 'port' in a packed multi-port bus of 'width'-bit lanes
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: picks bypass data, masks zero/out-of-range/clearing
// reads, and holds data when not enabled.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int ADDR_W   = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              clearing,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              in_range_s;
  logic              is_zero_s;
  logic [DATA_W-1:0] next_data_s;

  assign in_range_s = ({1'b0, rd_addr} < DEPTH_L);
  assign is_zero_s  = (ZERO_REG != 0) && (rd_addr == {ADDR_W{1'b0}});

  // Select the value this port will capture; wr_commit already excludes
  // out-of-range and hardwired-zero addresses, so bypass needs no extra mask
  always_comb begin
    next_data_s = {DATA_W{1'b0}};
    if (clearing) begin
      next_data_s = {DATA_W{1'b0}};
    end else if (!in_range_s || is_zero_s) begin
      next_data_s = {DATA_W{1'b0}};
    end else if (wr_commit && (wr_addr == rd_addr)) begin
      next_data_s = wr_data;
    end else begin
      next_data_s = mem_data;
    end
  end

  // Capture read data on enable; valid tracks the enable one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= {DATA_W{1'b0}};
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= next_data_s;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read / single-write register file with write-to-read
// bypass, optional hardwired-zero entry 0 and a sequential bulk-clear engine.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W   = $clog2(DEPTH)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clear_req,
  output logic                     clear_busy
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_in_range_s;
  logic wr_is_zero_s;
  logic wr_commit_s;
  logic clearing_s;

  // Writes are only accepted while idle and not colliding with a clear start
  assign wr_ready      = (state == IDLE) && !clear_req;
  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  assign wr_is_zero_s  = (ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}});
  assign wr_commit_s   = wr_en && wr_ready && wr_in_range_s && !wr_is_zero_s;
  assign clearing_s    = (state == CLEAR);

  // Clear-engine FSM: one entry per cycle, busy flag registered alongside state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sweep_cnt  <= {ADDR_W{1'b0}};
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            sweep_cnt  <= {ADDR_W{1'b0}};
            clear_busy <= 1'b1;
          end else begin
            clear_busy <= 1'b0;
          end
        end
        CLEAR: begin
          if (sweep_cnt == LAST_L) begin
            state      <= IDLE;
            sweep_cnt  <= {ADDR_W{1'b0}};
            clear_busy <= 1'b0;
          end else begin
            sweep_cnt  <= sweep_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            clear_busy <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          sweep_cnt  <= {ADDR_W{1'b0}};
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep zeroing takes priority; user writes are blocked while sweeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= {DATA_W{1'b0}};
      end
    end else if (clearing_s) begin
      mem[sweep_cnt] <= {DATA_W{1'b0}};
    end else if (wr_commit_s) begin
      mem[wr_addr] <= wr_data;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= mem[e];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] fetch_s;

    assign addr_s = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];

    // Storage fetch for this port, guarded so unpopulated addresses never index memory
    always_comb begin
      fetch_s = {DATA_W{1'b0}};
      if ({1'b0, addr_s} < DEPTH_L) begin
        fetch_s = mem[addr_s];
      end else begin
        fetch_s = {DATA_W{1'b0}};
      end
    end

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en[i]),
      .rd_addr   (addr_s),
      .mem_data  (fetch_s),
      .clearing  (clearing_s),
      .wr_commit (wr_commit_s),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[port_lsb(i, DATA_W) +: DATA_W]),
      .rd_valid  (rd_valid[i])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised bench for regfile_multiport: a 16-entry and a 12-entry instance
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        clear_req;

  logic        wr_ready_a, wr_ready_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        clear_busy_a, clear_busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_a), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .clear_req(clear_req), .clear_busy(clear_busy_a)
  );

  regfile_multiport #(.DATA_W(16), .DEPTH(12), .NUM_RD(2), .ZERO_REG(1)) dut12 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_b), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .clear_req(clear_req), .clear_busy(clear_busy_b)
  );

  // Reference model: contents, remaining sweep cycles, expected read registers
  int          depth_m [2] = '{16, 12};
  logic [15:0] mem_m   [2][16];
  int          left_m  [2];
  logic [15:0] exp_data  [2][2];
  logic        exp_valid [2][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left_m[k] = 0;
      for (int a = 0; a < 16; a++) mem_m[k][a] = 16'h0000;
      for (int p = 0; p < 2; p++) begin
        exp_data[k][p]  = 16'h0000;
        exp_valid[k][p] = 1'b0;
      end
    end
  endtask

  // Advance the model by one rising edge using the currently applied inputs
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit idle;
      bit ready;
      idle  = (left_m[k] == 0);
      ready = idle && !clear_req;
      for (int p = 0; p < 2; p++) begin
        int a;
        a = (p == 0) ? int'(rd_addr[3:0]) : int'(rd_addr[7:4]);
        if (rd_en[p]) begin
          logic [15:0] v;
          v = 16'h0000;
          if (idle && a < depth_m[k] && a != 0)
            v = (ready && wr_en && int'(wr_addr) == a) ? wr_data : mem_m[k][a];
          exp_data[k][p]  = v;
          exp_valid[k][p] = 1'b1;
        end else begin
          exp_valid[k][p] = 1'b0;
        end
      end
      if (!idle) begin
        left_m[k]--;
      end else if (clear_req) begin
        left_m[k] = depth_m[k];
        for (int a = 0; a < 16; a++) mem_m[k][a] = 16'h0000;
      end else if (wr_en && int'(wr_addr) < depth_m[k] && wr_addr != 4'd0) begin
        mem_m[k][int'(wr_addr)] = wr_data;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, " busy_a"}, {31'd0, clear_busy_a}, {31'd0, left_m[0] > 0});
    check({where, " busy_b"}, {31'd0, clear_busy_b}, {31'd0, left_m[1] > 0});
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s valid_a%0d", where, p), {31'd0, rd_valid_a[p]}, {31'd0, exp_valid[0][p]});
      check($sformatf("%s valid_b%0d", where, p), {31'd0, rd_valid_b[p]}, {31'd0, exp_valid[1][p]});
      check($sformatf("%s data_a%0d", where, p), {16'd0, rd_data_a[p*16 +: 16]}, {16'd0, exp_data[0][p]});
      check($sformatf("%s data_b%0d", where, p), {16'd0, rd_data_b[p*16 +: 16]}, {16'd0, exp_data[1][p]});
    end
  endtask

  // Called just after a falling edge: apply inputs, check wr_ready, clock, check outputs
  task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1,
                          input logic clr);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_en     = re;
    rd_addr   = {ra1, ra0};
    clear_req = clr;
    #1;
    check("wr_ready_a", {31'd0, wr_ready_a}, {31'd0, (left_m[0] == 0) && !clr});
    check("wr_ready_b", {31'd0, wr_ready_b}, {31'd0, (left_m[1] == 0) && !clr});
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Asynchronous reset in the low clock phase, checked before any edge
  task automatic async_reset();
    wr_en = 1'b0; rd_en = 2'b00; clear_req = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
    rd_en = 2'b00; rd_addr = 8'h00; clear_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Read every address on both ports after reset
    for (int a = 0; a < 16; a++)
      do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'(a), 4'(15 - a), 1'b0);

    // Write then read through storage; then same-cycle bypass on both ports
    do_cycle(1'b1, 4'd5, 16'hBEEF, 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b0, 4'd0, 16'h0000, 2'b10, 4'd0, 4'd5, 1'b0);
    check("beef_port1", {16'd0, rd_data_a[31:16]}, 32'h0000BEEF);
    do_cycle(1'b1, 4'd7, 16'h1234, 2'b11, 4'd7, 4'd7, 1'b0);
    check("bypass_p0", {16'd0, rd_data_a[15:0]}, 32'h00001234);
    check("bypass_p1", {16'd0, rd_data_a[31:16]}, 32'h00001234);

    // Hardwired zero entry and out-of-range address on the 12-entry instance
    do_cycle(1'b1, 4'd0, 16'hFFFF, 2'b11, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b1, 4'd13, 16'h5555, 2'b11, 4'd13, 4'd13, 1'b0);
    do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'd13, 4'd13, 1'b0);
    check("oor_b", {16'd0, rd_data_b[15:0]}, 32'h00000000);
    check("inrange_a", {16'd0, rd_data_a[15:0]}, 32'h00005555);

    // Fill, then clear with a concurrent (dropped) write; reads during sweep
    for (int a = 0; a < 16; a++)
      do_cycle(1'b1, 4'(a), 16'hAAAA, 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b1, 4'd3, 16'h1111, 2'b00, 4'd0, 4'd0, 1'b1);
    busy_cnt = (clear_busy_a === 1'b1) ? 1 : 0;
    for (int c = 0; c < 19; c++) begin
      do_cycle(1'b1, 4'($urandom_range(15)), 16'($urandom), 2'b11,
               4'($urandom_range(15)), 4'($urandom_range(15)), (c == 4) ? 1'b1 : 1'b0);
      if (clear_busy_a === 1'b1) busy_cnt++;
    end
    check("busy_len", 32'(busy_cnt), 32'd16);
    for (int a = 0; a < 16; a++)
      do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'(a), 4'(a), 1'b0);

    // Abort a sweep with reset, then confirm writes resume
    for (int a = 0; a < 16; a++)
      do_cycle(1'b1, 4'(a), 16'hAAAA, 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b0, 4'd0, 16'h0000, 2'b00, 4'd0, 4'd0, 1'b1);
    repeat (5) do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'd9, 4'd2, 1'b0);
    async_reset();
    check_outputs("post_rst");
    do_cycle(1'b1, 4'd9, 16'h4242, 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b0, 4'd0, 16'h0000, 2'b11, 4'd9, 4'd2, 1'b0);
    check("resume_a", {16'd0, rd_data_a[15:0]}, 32'h00004242);

    // Randomised traffic with occasional clears and resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(599) == 0) begin
        async_reset();
      end else begin
        do_cycle(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), ($urandom_range(39) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
